// File: rtl/spi_slave_sync.sv
// SPI responder oversampled in clk (all CPOL/CPHA modes); ss_n fall->miso_oe SYNC_STAGES+1 clk, last sample->rx_valid SYNC_STAGES+2 clk.
// Backpressure: one-word TX holding reg (tx_ready), rx_valid held until rx_ready; unread words overwrite and flag rx_overrun.
module spi_slave_sync #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic              sck_i,
    input  logic              ss_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              tx_underrun,
    output logic              rx_overrun,
    input  logic              ovr_clr,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
    logic                   sck_d1_q;
    logic                   cpol_q, cpha_q, lsb_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [DATA_W-1:0]      hold_q, tx_sr_q, rx_sr_q, rx_data_q;
    logic                   hold_full_q, miso_q, miso_oe_q, busy_q;
    logic                   rx_valid_q, rx_overrun_q, tx_underrun_q, frame_err_q;

    logic              sck_s, ss_s, mosi_s, sck_rise, sck_fall;
    logic              sample_edge, shift_edge, last_sample;
    logic              start, load_en, sample_en, drive_en, commit_en, abort_err;
    logic [DATA_W-1:0] load_word, tx_src, tx_next, rx_next;
    logic              tx_first;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign ss_s     = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d1_q;
    assign sck_fall = ~sck_s & sck_d1_q;

    // Sample on rising edge when cpol==cpha, otherwise on falling edge.
    assign sample_edge = (cpol_q == cpha_q) ? sck_rise : sck_fall;
    assign shift_edge  = (cpol_q == cpha_q) ? sck_fall : sck_rise;
    assign last_sample = sample_edge && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A final sample coinciding with ss_n rise still completes the word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!ss_s) state_d = LOAD;
            LOAD:    state_d = ss_s ? IDLE : SHIFT;
            SHIFT: begin
                if (last_sample)  state_d = DONE;
                else if (ss_s)    state_d = IDLE;
            end
            DONE:    state_d = ss_s ? IDLE : LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start     = (state_q == IDLE) && !ss_s;
        load_en   = (state_q == LOAD) && !ss_s;
        sample_en = (state_q == SHIFT) && sample_edge;
        // With cpha=0 the first bit is already on the line, so skip shift edges before the first sample.
        drive_en  = (state_q == SHIFT) && !ss_s && shift_edge && (cpha_q || (cnt_q != '0));
        commit_en = (state_q == DONE);
        abort_err = (state_q == SHIFT) && ss_s && !last_sample && (cnt_q != '0);
    end

    always_comb begin
        load_word = hold_full_q ? hold_q : '1;
        tx_src    = load_en ? load_word : tx_sr_q;
        tx_first  = lsb_q ? tx_src[0] : tx_src[DATA_W-1];
        tx_next   = lsb_q ? {1'b0, tx_src[DATA_W-1:1]} : {tx_src[DATA_W-2:0], 1'b0};
        rx_next   = lsb_q ? {mosi_s, rx_sr_q[DATA_W-1:1]} : {rx_sr_q[DATA_W-2:0], mosi_s};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q    <= '0;
            ss_sync_q     <= '1;
            mosi_sync_q   <= '0;
            sck_d1_q      <= 1'b0;
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
            lsb_q         <= 1'b0;
            cnt_q         <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            tx_sr_q       <= '0;
            rx_sr_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_err_q   <= 1'b0;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sck_d1_q    <= sck_s;

            if (start) begin
                cpol_q <= cpol;
                cpha_q <= cpha;
                lsb_q  <= lsb_first;
            end

            if ((state_d == IDLE) || commit_en || load_en) begin
                cnt_q <= '0;
            end else if (sample_en) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (load_en) begin
                hold_full_q <= 1'b0;
            end
            if (tx_valid && !hold_full_q) begin
                hold_q      <= tx_data;
                hold_full_q <= 1'b1;
            end
            tx_underrun_q <= load_en && !hold_full_q;

            if (state_d == IDLE) begin
                miso_q <= 1'b0;
            end else if ((load_en && !cpha_q) || drive_en) begin
                miso_q  <= tx_first;
                tx_sr_q <= tx_next;
            end else if (load_en) begin
                tx_sr_q <= tx_src;
            end

            if (sample_en) begin
                rx_sr_q <= rx_next;
            end

            if (commit_en) begin
                rx_data_q  <= rx_sr_q;
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            if (commit_en && rx_valid_q && !rx_ready) begin
                rx_overrun_q <= 1'b1;
            end else if (ovr_clr) begin
                rx_overrun_q <= 1'b0;
            end

            frame_err_q <= abort_err;
            miso_oe_q   <= (state_d != IDLE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign miso_o      = miso_q;
    assign miso_oe     = miso_oe_q;
    assign tx_ready    = ~hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = tx_underrun_q;
    assign rx_overrun  = rx_overrun_q;
    assign frame_err   = frame_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: behavioural SPI master, pulse monitors, hand-computed expectations.
module tb_spi_slave_sync;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
    logic       sck_i = 1'b0, ss_n_i = 1'b1, mosi_i = 1'b0;
    logic       miso_o, miso_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       tx_underrun, rx_overrun, frame_err, busy;
    logic       ovr_clr = 1'b0;

    int n_chk = 0, n_fail = 0;
    int n_undr = 0, n_ferr = 0, n_txrdy = 0, n_rx = 0;
    logic       tx_ready_prev = 1'b1;
    logic [7:0] rx_log [16];

    spi_slave_sync #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
        .sck_i(sck_i), .ss_n_i(ss_n_i), .mosi_i(mosi_i), .miso_o(miso_o), .miso_oe(miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_underrun(tx_underrun), .rx_overrun(rx_overrun), .ovr_clr(ovr_clr),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_underrun) n_undr++;
        if (frame_err) n_ferr++;
        if (tx_ready && !tx_ready_prev) n_txrdy++;
        tx_ready_prev = tx_ready;
        if (rx_valid && rx_ready && n_rx < 16) begin
            rx_log[n_rx] = rx_data;
            n_rx++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_mode(input logic p, input logic h, input logic l);
        cpol = p;
        cpha = h;
        lsb_first = l;
    endtask

    task automatic tx_push(input logic [7:0] d);
        int t;
        t = 0;
        while (!tx_ready && t < 50) begin
            wait_clk(1);
            t++;
        end
        chk("tx_rdy_pre", tx_ready, 1);
        tx_data = d;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
    endtask

    task automatic rx_accept();
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
    endtask

    task automatic frame_begin();
        sck_i = cpol;
        wait_clk(4);
        ss_n_i = 1'b0;
        wait_clk(6);
    endtask

    // last=1 raises ss_n together with the final sample edge.
    task automatic spi_word(input logic [7:0] mo, input int nbits, input bit last,
                            output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            int b;
            b = lsb_first ? i : 7 - i;
            if (!cpha) begin
                mosi_i = mo[b];
                wait_clk(HALF);
                mi[b] = miso_o;
                sck_i = ~cpol;
                if (last && i == nbits - 1) ss_n_i = 1'b1;
                wait_clk(HALF);
                sck_i = cpol;
            end else begin
                sck_i = ~cpol;
                mosi_i = mo[b];
                wait_clk(HALF);
                mi[b] = miso_o;
                sck_i = cpol;
                if (last && i == nbits - 1) ss_n_i = 1'b1;
                wait_clk(HALF);
            end
        end
    endtask

    task automatic chk_reset_vals(input string ph);
        chk({ph, "_miso"}, miso_o, 0);
        chk({ph, "_miso_oe"}, miso_oe, 0);
        chk({ph, "_tx_ready"}, tx_ready, 1);
        chk({ph, "_rx_data"}, rx_data, 0);
        chk({ph, "_rx_valid"}, rx_valid, 0);
        chk({ph, "_underrun"}, tx_underrun, 0);
        chk({ph, "_overrun"}, rx_overrun, 0);
        chk({ph, "_frame_err"}, frame_err, 0);
        chk({ph, "_busy"}, busy, 0);
    endtask

    initial begin
        logic [7:0] mi0, mi1;
        int b_rx, b_tr, b_un, b_fe;

        wait_clk(3);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        wait_clk(4);
        chk_reset_vals("post_rst");

        // Mode 0, MSB first
        set_mode(1'b0, 1'b0, 1'b0);
        b_un = n_undr; b_fe = n_ferr;
        tx_push(8'h3C);
        chk("m0_tx_ready_drop", tx_ready, 0);
        frame_begin();
        chk("m0_busy", busy, 1);
        chk("m0_miso_oe", miso_oe, 1);
        chk("m0_tx_ready_moved", tx_ready, 1);
        spi_word(8'hA5, 8, 1'b1, mi0);
        wait_clk(HALF);
        chk("m0_miso_word", mi0, 8'h3C);
        chk("m0_rx_data", rx_data, 8'hA5);
        chk("m0_rx_valid", rx_valid, 1);
        chk("m0_busy_end", busy, 0);
        chk("m0_miso_oe_end", miso_oe, 0);
        chk("m0_miso_end", miso_o, 0);
        chk("m0_no_underrun", n_undr - b_un, 0);
        chk("m0_no_frame_err", n_ferr - b_fe, 0);
        rx_accept();
        chk("m0_rx_valid_clr", rx_valid, 0);

        // Mode 3, LSB first
        set_mode(1'b1, 1'b1, 1'b1);
        tx_push(8'h81);
        frame_begin();
        spi_word(8'h0F, 8, 1'b1, mi0);
        wait_clk(HALF);
        chk("m3_miso_word", mi0, 8'h81);
        chk("m3_rx_data", rx_data, 8'h0F);
        chk("m3_rx_valid", rx_valid, 1);
        rx_accept();

        // Modes 1 and 2, back-to-back words with consumer always ready
        for (int m = 1; m <= 2; m++) begin
            set_mode(m[1], m[0], 1'b0);
            rx_ready = 1'b1;
            b_rx = n_rx; b_tr = n_txrdy; b_un = n_undr;
            tx_push(8'h55);
            frame_begin();
            tx_push(8'hAA);
            spi_word(8'h12, 8, 1'b0, mi0);
            spi_word(8'h34, 8, 1'b1, mi1);
            wait_clk(HALF);
            rx_ready = 1'b0;
            chk($sformatf("m%0d_miso_w0", m), mi0, 8'h55);
            chk($sformatf("m%0d_miso_w1", m), mi1, 8'hAA);
            chk($sformatf("m%0d_rx_count", m), n_rx - b_rx, 2);
            chk($sformatf("m%0d_rx_w0", m), rx_log[b_rx], 8'h12);
            chk($sformatf("m%0d_rx_w1", m), rx_log[b_rx + 1], 8'h34);
            chk($sformatf("m%0d_tx_ready_rises", m), n_txrdy - b_tr, 2);
            chk($sformatf("m%0d_no_underrun", m), n_undr - b_un, 0);
        end

        // Underrun: nothing loaded
        set_mode(1'b0, 1'b0, 1'b0);
        chk("ur_tx_empty", tx_ready, 1);
        b_un = n_undr;
        frame_begin();
        spi_word(8'h5A, 8, 1'b1, mi0);
        wait_clk(HALF);
        chk("ur_miso_word", mi0, 8'hFF);
        chk("ur_pulses", n_undr - b_un, 1);
        chk("ur_rx_data", rx_data, 8'h5A);
        rx_accept();

        // Overrun: two words, consumer not ready
        b_un = n_undr;
        frame_begin();
        spi_word(8'h11, 8, 1'b0, mi0);
        spi_word(8'h22, 8, 1'b1, mi1);
        wait_clk(HALF);
        chk("ov_rx_data", rx_data, 8'h22);
        chk("ov_rx_valid", rx_valid, 1);
        chk("ov_overrun", rx_overrun, 1);
        chk("ov_miso_w1", mi1, 8'hFF);
        chk("ov_underruns", n_undr - b_un, 2);
        ovr_clr = 1'b1;
        wait_clk(1);
        ovr_clr = 1'b0;
        wait_clk(1);
        chk("ov_cleared", rx_overrun, 0);
        chk("ov_rx_valid_kept", rx_valid, 1);
        rx_accept();

        // ss_n rises after 5 bits
        b_fe = n_ferr;
        frame_begin();
        spi_word(8'hC3, 5, 1'b0, mi0);
        wait_clk(HALF);
        ss_n_i = 1'b1;
        wait_clk(8);
        chk("fe_pulses", n_ferr - b_fe, 1);
        chk("fe_rx_valid", rx_valid, 0);
        chk("fe_busy", busy, 0);
        chk("fe_miso_oe", miso_oe, 0);

        // Reset in the middle of a frame with a full holding register
        frame_begin();
        tx_push(8'h99);
        chk("mr_tx_ready_full", tx_ready, 0);
        spi_word(8'hF0, 3, 1'b0, mi0);
        chk("mr_busy_before", busy, 1);
        rst_n = 1'b0;
        wait_clk(2);
        chk_reset_vals("mid_rst");
        ss_n_i = 1'b1;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(4);
        chk("mr_idle_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
